// File: rtl/palette_ram_dp.sv
// ---------------------------------------------------------------------------
// palette_ram_dp
//   Dual-port palette memory. CPU writes are queued in a small FIFO and only
//   committed to the RAM while commit_en is high (e.g. during blanking). The
//   video side reads through an independent pipelined port. After reset the
//   block walks every index and writes zero before accepting commits.
//
// Ports
//   clk        single clock for all logic
//   reset      asynchronous, active-high reset
//   wr_valid   CPU offers a palette write
//   wr_ready   queue can accept (transfer on wr_valid & wr_ready)
//   wr_addr    palette index to write
//   wr_data    colour value to write
//   commit_en  commit window; queued writes reach the RAM only while high
//   rd_en      video read request
//   rd_addr    palette index to read
//   rd_data    read result (holds when rd_valid is low)
//   rd_valid   rd_en delayed by the read latency (1 + OUT_REG)
//   busy       clear sequence in progress
//   pending    number of queued, uncommitted writes
// ---------------------------------------------------------------------------
module palette_ram_dp #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int OUT_REG = 1,
   parameter int QDEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     commit_en,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     busy,
   output logic [$clog2(QDEPTH):0]  pending
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_cnt;
   logic                rdy_en;

   logic [DATA_W-1:0]   mem    [DEPTH];
   logic [ADDR_W-1:0]   q_addr [QDEPTH];
   logic [DATA_W-1:0]   q_data [QDEPTH];
   logic [PTR_W-1:0]    wptr;
   logic [PTR_W-1:0]    rptr;
   logic [CNT_W-1:0]    count;

   logic                push;
   logic                pop;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;

   logic                vld_p0;
   logic [DATA_W-1:0]   data_p0;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_CLEAR;
      else       state <= state_nxt;
   end

   // Next state; CLEAR ends after the last index has been written
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         S_CLEAR: begin
            busy = 1'b1;
            if (clr_cnt == '1) state_nxt = S_IDLE;
         end
         default: ;
      endcase
   end

   // rdy_en keeps wr_ready low while reset is held and until the first clock
   // after release. Readiness is based on the registered count only, so a pop
   // in the same cycle never lets a write into a full queue.
   assign wr_ready = rdy_en && (count < QFULL);
   assign push     = wr_valid && wr_ready;
   assign pop      = (state == S_IDLE) && commit_en && (count != '0);
   assign pending  = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_cnt <= '0;
         rdy_en  <= 1'b0;
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (push)             wptr    <= wptr + 1'b1;
         if (pop)              rptr    <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wptr] <= wr_addr;
         q_data[wptr] <= wr_data;
      end
   end

   // RAM write port: clear sweep has priority, commits only happen in IDLE
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
      if (state == S_CLEAR) begin
         ram_we = 1'b1;
      end else if (pop) begin
         ram_we    = 1'b1;
         ram_waddr = q_addr[rptr];
         ram_wdata = q_data[rptr];
      end
   end

   // Nonblocking update gives read-before-write on a same-cycle collision
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
   end

   // Stage p0: synchronous RAM read; reads issued during the clear return 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_p0 <= 1'b0;
      else       vld_p0 <= rd_en;
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic vld_p1;

         always_ff @(posedge clk) begin
            if (rd_en) data_p0 <= busy ? '0 : mem[rd_addr];
         end

         // Stage p1: output register, holds when no read arrives
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vld_p1  <= 1'b0;
               rd_data <= '0;
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) rd_data <= data_p0;
            end
         end

         assign rd_valid = vld_p1;
      end else begin : g_noreg
         always_ff @(posedge clk or posedge reset) begin
            if (reset)      data_p0 <= '0;
            else if (rd_en) data_p0 <= busy ? '0 : mem[rd_addr];
         end

         assign rd_data  = data_p0;
         assign rd_valid = vld_p0;
      end
   endgenerate

endmodule

// File: tb/tb_palette_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_palette_ram_dp
//   Drives two instances (OUT_REG=1 and OUT_REG=0) with identical stimulus.
//   A reference model (array memory, queue of pending writes, clear countdown,
//   read delay lines) predicts every output each cycle; directed sequences,
//   a vector table and a random phase exercise the block.
// ---------------------------------------------------------------------------
module tb_palette_ram_dp;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int QD    = 2;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          commit_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   logic          wr_ready1, rd_valid1, busy1;
   logic [DW-1:0] rd_data1;
   logic [1:0]    pending1;
   logic          wr_ready0, rd_valid0, busy0;
   logic [DW-1:0] rd_data0;
   logic [1:0]    pending0;

   palette_ram_dp #(.ADDR_W(AW), .DATA_W(DW), .OUT_REG(1), .QDEPTH(QD)) u_dut1 (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1),
      .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .busy(busy1), .pending(pending1));

   palette_ram_dp #(.ADDR_W(AW), .DATA_W(DW), .OUT_REG(0), .QDEPTH(QD)) u_dut0 (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0),
      .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .busy(busy0), .pending(pending0));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic [DW-1:0] m_mem [DEPTH];
   wr_t           m_q [$];
   int            m_clr_left;
   bit            m_started;
   bit            m_s1_vld;
   logic [DW-1:0] m_s1_dat;
   bit            m_v0, m_v1;
   logic [DW-1:0] m_d0, m_d1;

   task automatic model_reset();
      m_q.delete();
      m_clr_left = DEPTH;
      m_started  = 1'b0;
      m_s1_vld   = 1'b0;
      m_s1_dat   = '0;
      m_v0 = 1'b0; m_v1 = 1'b0;
      m_d0 = '0;   m_d1 = '0;
   endtask

   task automatic compare_all();
      logic exp_rdy;
      exp_rdy = m_started && (m_q.size() < QD);
      check("wr_ready1", 32'(wr_ready1), 32'(exp_rdy));
      check("wr_ready0", 32'(wr_ready0), 32'(exp_rdy));
      check("pending1",  32'(pending1),  32'(m_q.size()));
      check("pending0",  32'(pending0),  32'(m_q.size()));
      check("busy1",     32'(busy1),     32'(m_clr_left > 0));
      check("busy0",     32'(busy0),     32'(m_clr_left > 0));
      check("rd_valid1", 32'(rd_valid1), 32'(m_v1));
      check("rd_valid0", 32'(rd_valid0), 32'(m_v0));
      check("rd_data1",  32'(rd_data1),  32'(m_d1));
      check("rd_data0",  32'(rd_data0),  32'(m_d0));
   endtask

   // One clock: predict from pre-edge inputs, advance model, compare at +1
   task automatic cyc();
      logic [DW-1:0] rval;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      bit acc, com, re;
      re   = rd_en;
      rval = (m_clr_left > 0) ? '0 : m_mem[rd_addr];
      acc  = wr_valid && m_started && (m_q.size() < QD);
      com  = (m_clr_left == 0) && commit_en && (m_q.size() > 0);
      wa   = wr_addr;
      wd   = wr_data;
      @(posedge clk);
      m_v1 = m_s1_vld;
      if (m_s1_vld) m_d1 = m_s1_dat;
      m_s1_vld = re;
      if (re) m_s1_dat = rval;
      m_v0 = re;
      if (re) m_d0 = rval;
      if (com) begin
         m_mem[m_q[0].a] = m_q[0].d;
         void'(m_q.pop_front());
      end
      if (acc) m_q.push_back(wr_t'{a: wa, d: wd});
      if (m_clr_left > 0) begin
         m_mem[AW'(DEPTH - m_clr_left)] = '0;
         m_clr_left--;
      end
      m_started = 1'b1;
      #1;
      compare_all();
   endtask

   // Asynchronous reset pulse, asserted and released between clock edges
   task automatic do_reset();
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_rd_valid1", 32'(rd_valid1), 32'd0);
      check("rst_rd_valid0", 32'(rd_valid0), 32'd0);
      check("rst_rd_data1",  32'(rd_data1),  32'd0);
      check("rst_pending",   32'(pending1),  32'd0);
      check("rst_busy",      32'(busy1),     32'd1);
      check("rst_wr_ready",  32'(wr_ready1), 32'd0);
      wr_valid  = 1'b0;
      commit_en = 1'b0;
      rd_en     = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok;
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = wr_ready1;
         cyc();
      end
      wr_valid = 1'b0;
      if (!ok) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      cyc();
      rd_en = 1'b0;
      check($sformatf("rd0_valid_%0d", a), 32'(rd_valid0), 32'd1);
      check($sformatf("rd0_data_%0d", a),  32'(rd_data0),  32'(exp));
      cyc();
      check($sformatf("rd1_valid_%0d", a), 32'(rd_valid1), 32'd1);
      check($sformatf("rd1_data_%0d", a),  32'(rd_data1),  32'(exp));
   endtask

   // Runs until busy falls; returns the number of clocks it took
   task automatic run_clear(output int n, output int first_v1, output int first_v0);
      n = 0; first_v1 = -1; first_v0 = -1;
      do begin
         cyc();
         n++;
         if (rd_valid1 && first_v1 < 0) first_v1 = n;
         if (rd_valid0 && first_v0 < 0) first_v0 = n;
      end while (busy1 && n < 40);
   endtask

   typedef struct {
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          ce;
      logic          re;
      logic [AW-1:0] ra;
      logic          rdy_pre;
      logic          rdy;
      logic [1:0]    pend;
      logic          chk_rd;
      logic [DW-1:0] exp_rd;
   } vec_t;

   function automatic vec_t mk(int wv, int wa, int wd, int ce, int re, int ra,
                               int rp, int r, int p, int c, int e);
      vec_t v;
      v.wv = 1'(wv); v.wa = AW'(wa); v.wd = DW'(wd); v.ce = 1'(ce);
      v.re = 1'(re); v.ra = AW'(ra); v.rdy_pre = 1'(rp); v.rdy = 1'(r);
      v.pend = 2'(p); v.chk_rd = 1'(c); v.exp_rd = DW'(e);
      return v;
   endfunction

   vec_t tbl [16];

   initial begin
      int n, fv1, fv0;

      // commit window, then full queue with a simultaneous pop
      tbl[0]  = mk(1, 1, 'h11, 0, 0, 0, 1, 1, 1, 0, 'h00);
      tbl[1]  = mk(1, 1, 'h22, 0, 0, 0, 1, 0, 2, 0, 'h00);
      tbl[2]  = mk(1, 2, 'h99, 0, 0, 0, 0, 0, 2, 0, 'h00);
      tbl[3]  = mk(1, 2, 'h99, 0, 1, 1, 0, 0, 2, 0, 'h00);
      tbl[4]  = mk(0, 0, 'h00, 0, 0, 0, 0, 0, 2, 1, 'h00);
      tbl[5]  = mk(0, 0, 'h00, 1, 0, 0, 0, 1, 1, 0, 'h00);
      tbl[6]  = mk(0, 0, 'h00, 1, 0, 0, 1, 1, 0, 0, 'h00);
      tbl[7]  = mk(0, 0, 'h00, 0, 1, 1, 1, 1, 0, 0, 'h00);
      tbl[8]  = mk(0, 0, 'h00, 0, 0, 0, 1, 1, 0, 1, 'h22);
      tbl[9]  = mk(1, 6, 'h61, 0, 0, 0, 1, 1, 1, 0, 'h00);
      tbl[10] = mk(1, 6, 'h62, 0, 0, 0, 1, 0, 2, 0, 'h00);
      tbl[11] = mk(1, 6, 'h63, 1, 0, 0, 0, 1, 1, 0, 'h00);
      tbl[12] = mk(1, 6, 'h63, 1, 0, 0, 1, 1, 1, 0, 'h00);
      tbl[13] = mk(0, 0, 'h00, 1, 0, 0, 1, 1, 0, 0, 'h00);
      tbl[14] = mk(0, 0, 'h00, 0, 1, 6, 1, 1, 0, 0, 'h00);
      tbl[15] = mk(0, 0, 'h00, 0, 0, 0, 1, 1, 0, 1, 'h63);

      // reset release and clear with continuous reads of index 5
      do_reset();
      rd_en   = 1'b1;
      rd_addr = 4'd5;
      run_clear(n, fv1, fv0);
      rd_en = 1'b0;
      check("clear_len", 32'(n), 32'd16);
      check("first_rd_valid1", 32'(fv1), 32'd2);
      check("first_rd_valid0", 32'(fv0), 32'd1);

      // writes queued during the clear drain only once busy falls
      do_reset();
      commit_en = 1'b1;
      push(4'd3, 8'hA5);
      push(4'd7, 8'h5A);
      n = 0;
      while (busy1 && n < 30) begin
         check("clr_hold_pending", 32'(pending1), 32'd2);
         cyc();
         n++;
      end
      check("clr_end_pending", 32'(pending1), 32'd2);
      cyc();
      check("drain1_pending", 32'(pending1), 32'd1);
      cyc();
      check("drain2_pending", 32'(pending1), 32'd0);
      commit_en = 1'b0;
      read_chk(4'd3, 8'hA5);
      read_chk(4'd7, 8'h5A);

      // vector table
      foreach (tbl[i]) begin
         wr_valid  = tbl[i].wv;
         wr_addr   = tbl[i].wa;
         wr_data   = tbl[i].wd;
         commit_en = tbl[i].ce;
         rd_en     = tbl[i].re;
         rd_addr   = tbl[i].ra;
         check($sformatf("tbl%0d_rdy_pre", i), 32'(wr_ready1), 32'(tbl[i].rdy_pre));
         cyc();
         check($sformatf("tbl%0d_rdy", i),  32'(wr_ready1), 32'(tbl[i].rdy));
         check($sformatf("tbl%0d_pend", i), 32'(pending1),  32'(tbl[i].pend));
         if (tbl[i].chk_rd) begin
            check($sformatf("tbl%0d_rvld", i), 32'(rd_valid1), 32'd1);
            check($sformatf("tbl%0d_rdat", i), 32'(rd_data1),  32'(tbl[i].exp_rd));
         end
      end
      wr_valid = 1'b0; commit_en = 1'b0; rd_en = 1'b0;

      // read/commit collision on index 4
      commit_en = 1'b1;
      push(4'd4, 8'h33);
      cyc();
      commit_en = 1'b0;
      push(4'd4, 8'h44);
      commit_en = 1'b1;
      rd_en     = 1'b1;
      rd_addr   = 4'd4;
      cyc();
      check("coll_old0", 32'(rd_data0), 32'h33);
      commit_en = 1'b0;
      cyc();
      check("coll_new0", 32'(rd_data0), 32'h44);
      check("coll_old1", 32'(rd_data1), 32'h33);
      rd_en = 1'b0;
      cyc();
      check("coll_new1", 32'(rd_data1), 32'h44);

      // mid-operation reset with queued writes and reads in flight
      push(4'd9, 8'h91);
      push(4'd9, 8'h92);
      rd_en   = 1'b1;
      rd_addr = 4'd3;
      cyc();
      cyc();
      check("pre_rst_pending", 32'(pending1), 32'd2);
      check("pre_rst_rvld",    32'(rd_valid1), 32'd1);
      do_reset();
      run_clear(n, fv1, fv0);
      check("rst_clear_len", 32'(n), 32'd16);
      read_chk(4'd3, 8'h00);
      read_chk(4'd9, 8'h00);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         wr_valid  = 1'($urandom_range(0, 1));
         wr_addr   = AW'($urandom);
         wr_data   = DW'($urandom);
         commit_en = ($urandom_range(0, 3) != 0);
         rd_en     = 1'($urandom_range(0, 1));
         rd_addr   = AW'($urandom);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/palette_ram_dp.md
Name: palette_ram_dp

Overview:
- Parametrised dual-port palette memory, the successor to the single-port 16x8 palette store.
- The CPU palette-write path pushes entries into a small write queue.
- Queued entries are committed to the RAM only while the video timing asserts a commit window, for example blanking.
- The video pipeline reads colours through an independent, pipelined read port. After reset the block self-clears every entry to zero.

Parameters:
- ADDR_W, 4, palette index width; depth = 2**ADDR_W entries.
- DATA_W, 8, colour word width.
- OUT_REG, 1, extra output register on the read port (0 or 1).
- QDEPTH, 2, write-queue depth in entries (power of two, 2..8).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  CPU offers a palette write.
- wr_ready  out  1  queue can accept; a transfer occurs when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  palette index to write.
- wr_data  in  DATA_W  colour value to write.
- commit_en  in  1  commit window; queued writes may reach the RAM only while this is high.
- rd_en  in  1  video read request.
- rd_addr  in  ADDR_W  palette index to read.
- rd_data  out  DATA_W  read result.
- rd_valid  out  1  rd_data holds the result of a read issued 1+OUT_REG cycles earlier.
- busy  out  1  clear sequence is in progress.
- pending  out  $clog2(QDEPTH)+1  number of queued, uncommitted writes.

Behaviour:
- Reset values (asynchronous): rd_data=0, rd_valid=0, pending=0, queue empty, clear counter=0, state=CLEAR, busy=1. wr_ready=1 from the first clock after reset deasserts; it is 0 while reset is high.
- Reset asserted mid-operation: queued writes are discarded, the read pipeline is flushed, and the clear sequence restarts from index 0.
- State CLEAR:
  - Writes 0 to address = counter every cycle.
  - The counter increments each cycle; after writing index 2**ADDR_W-1 the state moves to IDLE. busy falls in the same cycle the state becomes IDLE, so CLEAR lasts exactly 2**ADDR_W cycles.
  - The queue still accepts writes but does not drain.
  - Reads issued while in CLEAR return 0 regardless of RAM contents.
- State IDLE:
  - Each cycle with commit_en=1 and pending>0, the queue head is popped and written to the RAM that cycle.
  - At most one commit per cycle.
  - Commits are in strict FIFO order, so the last write to an index wins.
- Queue rules:
  - wr_ready = (pending < QDEPTH).
  - When full, wr_ready stays 0 even if a pop happens in the same cycle (no full-bypass).
  - Simultaneous push and pop when not full: pending is unchanged.
  - pending updates one cycle after the handshake or pop edge.
  - Pointers wrap modulo QDEPTH.
- Read port:
  - Synchronous RAM read with latency 1+OUT_REG cycles; fully pipelined, one read accepted per cycle.
  - rd_valid is rd_en delayed by the same latency.
  - rd_data holds its last value when rd_valid=0.
- Read/commit collision: a read and a commit to the same address in the same cycle return the OLD data (read-before-write). The new value is visible to a read issued the following cycle.
- No write bypass: a queued write is never visible on rd_data until it has been committed.
- Width rules: addresses are used unsigned with no range check; all indices 0..2**ADDR_W-1 are valid.

Test Plan:
- Reset release, defaults, and rd_en=1 to rd_addr=5 every cycle:
  - busy=1 for exactly 16 cycles.
  - rd_data=0 throughout the clear.
  - rd_valid first rises 2 cycles after the first rd_en.
- Clear interlock: push (3,0xA5) and (7,0x5A) during CLEAR with commit_en=1.
  - pending=2 until busy falls, then drains to 0 over 2 cycles.
  - Reads then return 0xA5 at index 3 and 0x5A at index 7.
- Commit window: with commit_en=0, push (1,0x11) and (1,0x22).
  - wr_ready drops after the second push; a third wr_valid is stalled.
  - Reads of index 1 return 0x00.
  - Raise commit_en: after the 2-cycle drain, index 1 reads 0x22.
- Full + simultaneous pop: QDEPTH=2, queue full, commit_en rises together with wr_valid.
  - wr_ready stays 0 in that cycle and returns to 1 the next cycle.
  - The stalled write is accepted then and committed in order.
- Read/commit collision: index 4 holds 0x33; commit (4,0x44) while reading index 4 in the same cycle.
  - That read returns 0x33; the next-cycle read returns 0x44.
  - Repeat with OUT_REG=0 and confirm latency is 1.
- Mid-operation reset: pulse reset asynchronously (between clock edges) with pending=2 and reads in flight.
  - rd_valid=0 and pending=0 immediately.
  - busy=1 and a full 16-cycle clear follows.
  - Index 3 then reads 0x00.
